grf_writeback: RTL

Writeback arbiter and scoreboard that drives the GRF write port. It merges single-cycle ALU/load results with long-latency multiply/divide results buffered in a small FIFO, and emits one registered write per cycle (`RegWrite`, `rd`, `WriteData`, `PC`). It also tracks registers with outstanding long-latency writes and raises `stall` to the issue stage on RAW/WAW hazards.

---
 rtl/grf_writeback.sv | 127 ++++++++++++
 1 files changed

// File: rtl/grf_writeback.sv
// grf_writeback: GRF write-port arbiter (ALU first, then buffered MDU results) with a
// scoreboard of long-latency destinations. Define GRF_WB_TRACE_EN for a per-write trace.
module grf_writeback #(
    parameter int DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic [31:0] alu_pc,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    input  logic [31:0] mdu_pc,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd_q,
    output logic        stall,
    output logic        RegWrite,
    output logic [4:0]  rd,
    output logic [31:0] WriteData,
    output logic [31:0] PC
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
    } wb_entry_t;

    wb_entry_t   fifo_mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        fifo_empty, fifo_full;
    logic        push, pop;
    wb_entry_t   head;

    wb_entry_t   out_q, out_d;
    logic        reg_write_q, reg_write_d;
    logic        from_fifo_q, from_fifo_d;
    logic [31:0] pending_q, pending_d;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head       = fifo_mem_q[rd_ptr_q[AW-1:0]];

    assign pop        = !alu_valid && !fifo_empty;
    assign mdu_ready  = !fifo_full || pop;
    assign push       = mdu_valid && mdu_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Fixed priority: ALU, then FIFO head, else idle with the address/data held.
    always_comb begin
        out_d       = out_q;
        reg_write_d = 1'b0;
        from_fifo_d = 1'b0;
        if (alu_valid) begin
            out_d       = '{rd: alu_rd, data: alu_data, pc: alu_pc};
            reg_write_d = (alu_rd != 5'd0);
        end else if (pop) begin
            out_d       = head;
            reg_write_d = (head.rd != 5'd0);
            from_fifo_d = 1'b1;
        end
    end

    // Clear lands on the same edge the GRF commits the FIFO write; a same-edge set wins.
    always_comb begin
        pending_d = pending_q;
        if (from_fifo_q) pending_d[out_q.rd] = 1'b0;
        if (issue_valid && (issue_rd != 5'd0)) pending_d[issue_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (!Rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_q       <= '0;
            reg_write_q <= 1'b0;
            from_fifo_q <= 1'b0;
            pending_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_q       <= out_d;
            reg_write_q <= reg_write_d;
            from_fifo_q <= from_fifo_d;
            pending_q   <= pending_d;
        end
    end

    // NOTE: FIFO storage has no reset; the pointers alone define which slots are valid.
    always_ff @(posedge Clk) begin
        if (push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= '{rd: mdu_rd, data: mdu_data, pc: mdu_pc};
    end

    assign stall     = pending_q[rs] | pending_q[rt] | pending_q[rd_q];
    assign RegWrite  = reg_write_q;
    assign rd        = out_q.rd;
    assign WriteData = out_q.data;
    assign PC        = out_q.pc;

`ifdef GRF_WB_TRACE_EN
    always @(posedge Clk) begin
        if (Rst_n && reg_write_q) $display("@%h: $%d <= %h", out_q.pc, out_q.rd, out_q.data);
    end
`else
    // Trace disabled: the design produces no simulation output.
`endif

endmodule
